// File: rtl/covariance_pkg.sv
// covariance_pkg: drain FSM state encodings and default array geometry shared with the control unit
package covariance_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FINISH = 2'd2} drain_state_t;
    localparam int DEF_N = 2;
    localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/drain_index_gen.sv
// drain_index_gen: row-major result index walker with last detect; DRAIN_SYMMETRIC_EN restricts to col >= row
module drain_index_gen import covariance_pkg::*; #(
    parameter int N = DEF_N
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       adv,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       last
);
    localparam logic [1:0] MAX = 2'(N - 1);
    logic [1:0] wrap_col;
`ifdef DRAIN_SYMMETRIC_EN
    assign wrap_col = row + 2'd1;
`else
    assign wrap_col = 2'd0;
`endif
    always_ff @(posedge clk) begin
        if (rst || load) begin
            row <= 2'd0;
            col <= 2'd0;
        end else if (adv) begin
            row <= (col == MAX) ? row + 2'd1 : row;
            col <= (col == MAX) ? wrap_col : col + 2'd1;
        end
    end
    assign last = (row == MAX) && (col == MAX);
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots an N x N PE result array and streams it out with valid/ready
// Build option: DRAIN_SYMMETRIC_EN streams only the upper triangle (col >= row).
module systolic_result_drain import covariance_pkg::*; #(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  array_done,
    input  logic [N*N*DATA_W-1:0] pe_result,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_row,
    output logic [1:0]            out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  drain_done,
    output logic                  overrun
);
    drain_state_t state, next;
    logic [N*N*DATA_W-1:0] snap;
    logic capture, accept, last;
    int idx;
    drain_index_gen #(.N(N)) u_idx (
        .clk(clk), .rst(rst), .load(capture), .adv(accept && !last),
        .row(out_row), .col(out_col), .last(last)
    );
    always_ff @(posedge clk) begin
        state   <= rst ? IDLE : next;
        overrun <= rst ? 1'b0 : (overrun || (array_done && state != IDLE));
        if (capture) snap <= pe_result;
    end
    always_comb begin
        capture    = (state == IDLE) && array_done;
        out_valid  = (state == STREAM);
        accept     = out_valid && out_ready;
        drain_done = (state == FINISH);
        busy       = (state != IDLE);
        out_last   = out_valid && last;
        idx        = int'(out_row) * N + int'(out_col);
        out_data   = out_valid ? snap[idx*DATA_W +: DATA_W] : '0;
        next       = state;
        case (state)
            IDLE:    next = array_done ? STREAM : IDLE;
            STREAM:  next = (accept && last) ? FINISH : STREAM;
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: scoreboard-driven directed checks of the result drain (N=2, DATA_W=16)
module tb_systolic_result_drain;
    localparam int N = 2;
    localparam int DATA_W = 16;
    logic clk = 1'b0;
    logic rst, array_done, out_ready;
    logic [N*N*DATA_W-1:0] pe_result, pat;
    logic [DATA_W-1:0] out_data;
    logic [1:0] out_row, out_col;
    logic out_valid, out_last, busy, drain_done, overrun;
    logic [20:0] sb[$];
    logic [20:0] pre;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    systolic_result_drain #(.N(N), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .array_done(array_done), .pe_result(pe_result),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .drain_done(drain_done),
        .overrun(overrun)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_matrix();
        logic [20:0] e;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
`ifdef DRAIN_SYMMETRIC_EN
                if (c < r) continue;
`endif
                sb.push_back({1'b0, 2'(r), 2'(c), 16'(17 + 16 * r + c)});
            end
        e = sb.pop_back();
        e[20] = 1'b1;
        sb.push_back(e);
    endtask

    task automatic start();
        pe_result = pat;
        array_done = 1'b1;
        push_matrix();
        tick();
        array_done = 1'b0;
        chk("latency_valid", 32'(out_valid), 32'd1);
    endtask

    // Walks the scoreboard front while optionally stalling or pulsing array_done.
    task automatic drain(input int stall_idx, input int stall_len, input int od_iter, input bit od_finish);
        logic [20:0] e;
        int n = 0;
        int stalled = 0;
        int guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            e = sb[0];
            chk("valid", 32'(out_valid), 32'd1);
            chk("data", 32'(out_data), 32'(e[15:0]));
            chk("row", 32'(out_row), 32'(e[19:18]));
            chk("col", 32'(out_col), 32'(e[17:16]));
            chk("last", 32'(out_last), 32'(e[20]));
            array_done = (guard == od_iter);
            if (n == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
                void'(sb.pop_front());
                n++;
            end
            guard++;
            tick();
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        out_ready = 1'b1;
        array_done = od_finish;
        chk("finish_done", 32'(drain_done), 32'd1);
        chk("finish_valid", 32'(out_valid), 32'd0);
        chk("finish_busy", 32'(busy), 32'd1);
        tick();
        array_done = 1'b0;
        chk("idle_done", 32'(drain_done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N * N; i++) pat[i*DATA_W +: DATA_W] = 16'(17 + 16 * (i / N) + (i % N));
        rst = 1'b1;
        array_done = 1'b0;
        out_ready = 1'b1;
        pe_result = pat;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_done", 32'(drain_done), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);

        start();
        drain(-1, 0, -1, 1'b0);
        chk("basic_overrun", 32'(overrun), 32'd0);

        start();
        drain(1, 3, -1, 1'b0);

        start();
        pe_result = {N*N{16'hAAAA}};
        drain(-1, 0, -1, 1'b0);

        start();
        drain(-1, 0, -1, 1'b1);
        chk("finish_overrun", 32'(overrun), 32'd1);
        tick();
        chk("finish_nocapture", 32'(busy), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("clr_overrun", 32'(overrun), 32'd0);

        start();
        pe_result = {N*N{16'hFFFF}};
        drain(-1, 0, 1, 1'b0);
        chk("stream_overrun", 32'(overrun), 32'd1);
        tick();
        tick();
        chk("overrun_sticky", 32'(overrun), 32'd1);

        start();
        tick();
        tick();
        pre = sb[2];
        chk("pre_rst_data", 32'(out_data), 32'(pre[15:0]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_row", 32'(out_row), 32'd0);
        start();
        drain(-1, 0, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
